wb_stage: RTL and testbench

Write-back stage of the five-stage pipelined MIPS core. It holds the M/W pipeline register and selects and extends the write-back value. It drives the register file's write port (address, data, enable, word-index PC) and supplies the W-stage forwarding source to the hazard logic. It also keeps a retired-instruction counter and flags misaligned loads.

---
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage.sv | 135 +++++++++++++
 tb/tb_wb_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// M-to-W pipeline bus for the write-back stage: M-stage fields in, register-file
// write port, forwarding qualifier and status out.
interface wb_stage_if;
  logic        Flush_In;
  logic        Valid_In;
  logic [31:0] Pc_In;
  logic        RegWrite_In;
  logic [4:0]  Dst_In;
  logic [1:0]  WdSel_In;
  logic [31:0] AluRes_In;
  logic [31:0] MemData_In;
  logic [31:0] Aux_In;
  logic [2:0]  LoadType_In;
  logic [1:0]  ByteOff_In;

  logic [31:0] Pc_Out;
  logic [4:0]  A3_Out;
  logic [31:0] Wd3_Out;
  logic        We3_Out;
  logic        FwdValid_Out;
  logic        Misalign_Out;
  logic        MisalignSticky_Out;
  logic [31:0] Retired_Out;

  modport master (
    output Flush_In, Valid_In, Pc_In, RegWrite_In, Dst_In, WdSel_In,
           AluRes_In, MemData_In, Aux_In, LoadType_In, ByteOff_In,
    input  Pc_Out, A3_Out, Wd3_Out, We3_Out, FwdValid_Out,
           Misalign_Out, MisalignSticky_Out, Retired_Out
  );

  modport slave (
    input  Flush_In, Valid_In, Pc_In, RegWrite_In, Dst_In, WdSel_In,
           AluRes_In, MemData_In, Aux_In, LoadType_In, ByteOff_In,
    output Pc_Out, A3_Out, Wd3_Out, We3_Out, FwdValid_Out,
           Misalign_Out, MisalignSticky_Out, Retired_Out
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: M/W register, write-data select and load extension,
// retired counter and misaligned-load flags. Macro WB_SUBWORD_LOAD_EN enables byte/half loads.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  wb_stage_if.slave   bus
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_regWrite;
  logic [4:0]  r_dst;
  logic [1:0]  r_wdSel;
  logic [31:0] r_aluRes;
  logic [31:0] r_memData;
  logic [31:0] r_aux;
  logic [2:0]  r_loadType;
  logic [1:0]  r_byteOff;
  logic        r_sticky;
  logic [31:0] r_retired;

  logic [31:0] w_loadData;
  logic [31:0] w_linkAddr;
  logic [31:0] w_wd;
  logic        w_memSel;
  logic        w_misalign;
  logic        w_we;

  // A flush captures a bubble; retire/sticky updates look at the instruction leaving W.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_regWrite <= 1'b0;
      r_dst      <= 5'd0;
      r_wdSel    <= 2'd0;
      r_aluRes   <= 32'd0;
      r_memData  <= 32'd0;
      r_aux      <= 32'd0;
      r_loadType <= 3'd0;
      r_byteOff  <= 2'd0;
      r_sticky   <= 1'b0;
      r_retired  <= 32'd0;
    end else begin
      if (r_valid) r_retired <= r_retired + 32'd1;
      if (w_misalign) r_sticky <= 1'b1;
      if (bus.Flush_In) begin
        r_valid    <= 1'b0;
        r_pc       <= RESET_PC;
        r_regWrite <= 1'b0;
        r_dst      <= 5'd0;
        r_wdSel    <= 2'd0;
        r_aluRes   <= 32'd0;
        r_memData  <= 32'd0;
        r_aux      <= 32'd0;
        r_loadType <= 3'd0;
        r_byteOff  <= 2'd0;
      end else begin
        r_valid    <= bus.Valid_In;
        r_pc       <= bus.Pc_In;
        r_regWrite <= bus.RegWrite_In;
        r_dst      <= bus.Dst_In;
        r_wdSel    <= bus.WdSel_In;
        r_aluRes   <= bus.AluRes_In;
        r_memData  <= bus.MemData_In;
        r_aux      <= bus.Aux_In;
        r_loadType <= bus.LoadType_In;
        r_byteOff  <= bus.ByteOff_In;
      end
    end
  end

  assign w_memSel = (r_wdSel == 2'b01);

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = r_memData[{r_byteOff, 3'b000} +: 8];
  assign w_half = r_byteOff[1] ? r_memData[31:16] : r_memData[15:0];

  // Little-endian lane pick; unknown load types behave as lw.
  always_comb begin
    w_loadData = r_memData;
    w_misalign = 1'b0;
    case (r_loadType)
      3'b001: w_loadData = {24'd0, w_byte};
      3'b010: w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b011: begin
        w_loadData = {16'd0, w_half};
        w_misalign = r_byteOff[0];
      end
      3'b100: begin
        w_loadData = {{16{w_half[15]}}, w_half};
        w_misalign = r_byteOff[0];
      end
      default: w_misalign = (r_byteOff != 2'd0);
    endcase
    w_misalign = w_misalign & r_valid & w_memSel;
  end
`else
  logic w_unusedLoadType;

  assign w_unusedLoadType = ^r_loadType;
  assign w_loadData       = r_memData;
  assign w_misalign       = r_valid & w_memSel & (r_byteOff != 2'd0);
`endif

  assign w_linkAddr = 32'h0000_3000 + {r_pc[29:0], 2'b00} + 32'd8;

  always_comb begin
    w_wd = r_aluRes;
    case (r_wdSel)
      2'b01:   w_wd = w_loadData;
      2'b10:   w_wd = w_linkAddr;
      2'b11:   w_wd = r_aux;
      default: w_wd = r_aluRes;
    endcase
  end

  // $0 writes still assert the enable; only forwarding excludes them.
  assign w_we = r_valid & r_regWrite & ~w_misalign;

  assign bus.Pc_Out             = r_pc;
  assign bus.A3_Out             = r_dst;
  assign bus.Wd3_Out            = w_wd;
  assign bus.We3_Out            = w_we;
  assign bus.FwdValid_Out       = w_we & (r_dst != 5'd0);
  assign bus.Misalign_Out       = w_misalign;
  assign bus.MisalignSticky_Out = r_sticky;
  assign bus.Retired_Out        = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against an
// arithmetic reference model of the W stage.
module tb_wb_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        regWrite;
    logic [4:0]  dst;
    logic [1:0]  wdSel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] aux;
    logic [2:0]  loadType;
    logic [1:0]  off;
  } minst_t;

  logic Clk;
  logic Reset;
  wb_stage_if bus ();

  wb_stage #(.RESET_PC(RESET_PC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checksTotal  = 0;
  int checksPassed = 0;

  minst_t      modelW;
  logic [31:0] modelRetired;
  logic        modelSticky;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic logic modelMisalign(input minst_t w);
    int off = int'(w.off);
    if (!w.valid || w.wdSel != 2'd1) return 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
    if (w.loadType == 3'd1 || w.loadType == 3'd2) return 1'b0;
    if (w.loadType == 3'd3 || w.loadType == 3'd4) return (off % 2) == 1;
`endif
    return off != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input minst_t w);
    longint b = (longint'(w.mem) >> (8 * int'(w.off))) % 256;
    longint h = (longint'(w.mem) >> (16 * (int'(w.off) / 2))) % 65536;
`ifdef WB_SUBWORD_LOAD_EN
    case (w.loadType)
      3'd1: return 32'(b);
      3'd2: return 32'(b >= 128 ? b - 256 : b);
      3'd3: return 32'(h);
      3'd4: return 32'(h >= 32768 ? h - 65536 : h);
      default: return w.mem;
    endcase
`else
    return w.mem;
`endif
  endfunction

  function automatic logic [31:0] modelWd(input minst_t w);
    case (w.wdSel)
      2'd0: return w.alu;
      2'd1: return modelLoad(w);
      2'd2: return 32'(64'h3000 + 4 * longint'(w.pc) + 8);
      default: return w.aux;
    endcase
  endfunction

  function automatic minst_t randInst();
    minst_t m;
    m.valid    = 1'($urandom_range(0, 3) != 0);
    m.pc       = $urandom;
    m.regWrite = 1'($urandom);
    m.dst      = 5'($urandom);
    m.wdSel    = 2'($urandom);
    m.alu      = $urandom;
    m.mem      = $urandom;
    m.aux      = $urandom;
    m.loadType = 3'($urandom);
    m.off      = 2'($urandom);
    return m;
  endfunction

  function automatic minst_t mkInst(input logic [31:0] pc, input logic [4:0] dst, input logic [1:0] wdSel,
                                    input logic [31:0] alu, input logic [31:0] mem,
                                    input logic [2:0] lt, input logic [1:0] off);
    minst_t m;
    m.valid = 1'b1; m.pc = pc; m.regWrite = 1'b1; m.dst = dst; m.wdSel = wdSel;
    m.alu = alu; m.mem = mem; m.aux = 32'hA5A5_0000; m.loadType = lt; m.off = off;
    return m;
  endfunction

  task automatic checkModel(input string tag);
    logic mis = modelMisalign(modelW);
    logic we  = modelW.valid && modelW.regWrite && !mis;
    checkOutput({tag, ".pc"},  bus.Pc_Out, modelW.pc);
    checkOutput({tag, ".a3"},  32'(bus.A3_Out), 32'(modelW.dst));
    checkOutput({tag, ".wd"},  bus.Wd3_Out, modelWd(modelW));
    checkOutput({tag, ".we"},  32'(bus.We3_Out), 32'(we));
    checkOutput({tag, ".fwd"}, 32'(bus.FwdValid_Out), 32'(we && modelW.dst != 5'd0));
    checkOutput({tag, ".mis"}, 32'(bus.Misalign_Out), 32'(mis));
    checkOutput({tag, ".sticky"}, 32'(bus.MisalignSticky_Out), 32'(modelSticky));
    checkOutput({tag, ".ret"}, bus.Retired_Out, modelRetired);
  endtask

  // Drive away from the edge, advance one clock, update the model, then sample.
  task automatic applyStimulus(input logic rst, input logic flush, input minst_t m);
    @(negedge Clk);
    Reset           = rst;
    bus.Flush_In    = flush;
    bus.Valid_In    = m.valid;
    bus.Pc_In       = m.pc;
    bus.RegWrite_In = m.regWrite;
    bus.Dst_In      = m.dst;
    bus.WdSel_In    = m.wdSel;
    bus.AluRes_In   = m.alu;
    bus.MemData_In  = m.mem;
    bus.Aux_In      = m.aux;
    bus.LoadType_In = m.loadType;
    bus.ByteOff_In  = m.off;
    @(posedge Clk);
    if (rst) begin
      modelW       = '0;
      modelW.pc    = RESET_PC;
      modelRetired = 32'd0;
      modelSticky  = 1'b0;
    end else begin
      if (modelW.valid) modelRetired = modelRetired + 32'd1;
      if (modelMisalign(modelW)) modelSticky = 1'b1;
      if (flush) begin
        modelW    = '0;
        modelW.pc = RESET_PC;
      end else begin
        modelW = m;
      end
    end
    #1;
  endtask

  initial begin
    minst_t      bubble;
    logic [31:0] memWord;
    logic [31:0] retSnap;
    bubble       = '0;
    modelW       = '0;
    modelRetired = 32'd0;
    modelSticky  = 1'b0;
    memWord      = 32'h80FF_7F01;

    applyStimulus(1'b1, 1'($urandom), randInst());
    applyStimulus(1'b1, 1'($urandom), randInst());
    checkModel("reset");
    checkOutput("reset.pcConst", bus.Pc_Out, RESET_PC);
    checkOutput("reset.wdConst", bus.Wd3_Out, 32'd0);

    applyStimulus(1'b0, 1'b0, mkInst(32'd5, 5'd8, 2'd0, 32'h1234_5678, 32'd0, 3'd0, 2'd0));
    checkModel("alu");
    checkOutput("alu.a3Const",  32'(bus.A3_Out), 32'd8);
    checkOutput("alu.wdConst",  bus.Wd3_Out, 32'h1234_5678);
    checkOutput("alu.weConst",  32'(bus.We3_Out), 32'd1);
    checkOutput("alu.fwdConst", 32'(bus.FwdValid_Out), 32'd1);
    checkOutput("alu.pcConst",  bus.Pc_Out, 32'd5);
    checkOutput("alu.ret0",     bus.Retired_Out, 32'd0);
    applyStimulus(1'b0, 1'b0, bubble);
    checkOutput("alu.ret1",     bus.Retired_Out, 32'd1);

`ifdef WB_SUBWORD_LOAD_EN
    applyStimulus(1'b0, 1'b0, mkInst(32'd6, 5'd9, 2'd1, 32'd0, memWord, 3'd2, 2'd3));
    checkOutput("lb3", bus.Wd3_Out, 32'hFFFF_FF80);
    applyStimulus(1'b0, 1'b0, mkInst(32'd7, 5'd9, 2'd1, 32'd0, memWord, 3'd1, 2'd1));
    checkOutput("lbu1", bus.Wd3_Out, 32'h0000_007F);
    applyStimulus(1'b0, 1'b0, mkInst(32'd8, 5'd9, 2'd1, 32'd0, memWord, 3'd4, 2'd2));
    checkOutput("lh2", bus.Wd3_Out, 32'hFFFF_80FF);
    applyStimulus(1'b0, 1'b0, mkInst(32'd9, 5'd9, 2'd1, 32'd0, memWord, 3'd3, 2'd0));
    checkOutput("lhu0", bus.Wd3_Out, 32'h0000_7F01);
    checkModel("lhu0");
`else
    applyStimulus(1'b0, 1'b0, mkInst(32'd6, 5'd9, 2'd1, 32'd0, memWord, 3'd2, 2'd0));
    checkOutput("rawLoad", bus.Wd3_Out, memWord);
    checkModel("rawLoad");
`endif
    checkOutput("noSticky", 32'(bus.MisalignSticky_Out), 32'd0);

    applyStimulus(1'b0, 1'b0, mkInst(32'h10, 5'd31, 2'd2, 32'd0, 32'd0, 3'd0, 2'd0));
    checkOutput("jal.wd", bus.Wd3_Out, 32'h0000_3048);
    checkModel("jal");
    applyStimulus(1'b0, 1'b0, mkInst(32'h11, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 3'd0, 2'd0));
    checkOutput("zero.we",  32'(bus.We3_Out), 32'd1);
    checkOutput("zero.fwd", 32'(bus.FwdValid_Out), 32'd0);

    applyStimulus(1'b0, 1'b0, mkInst(32'h12, 5'd4, 2'd1, 32'd0, memWord, 3'd0, 2'd2));
    retSnap = bus.Retired_Out;
    checkOutput("lwMis.we",  32'(bus.We3_Out), 32'd0);
    checkOutput("lwMis.mis", 32'(bus.Misalign_Out), 32'd1);
    applyStimulus(1'b1 ^ 1'b1, 1'b1, mkInst(32'h13, 5'd5, 2'd0, 32'h1, 32'd0, 3'd0, 2'd0));
    checkOutput("lwMis.sticky", 32'(bus.MisalignSticky_Out), 32'd1);
    checkOutput("lwMis.retInc", bus.Retired_Out, retSnap + 32'd1);
    checkOutput("flush.we",     32'(bus.We3_Out), 32'd0);
    checkOutput("flush.pc",     bus.Pc_Out, RESET_PC);
    applyStimulus(1'b0, 1'b0, bubble);
    checkOutput("flush.ret",    bus.Retired_Out, retSnap + 32'd1);
    checkOutput("flush.sticky", 32'(bus.MisalignSticky_Out), 32'd1);
    checkModel("flush");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) == 0), randInst());
      checkModel("rand");
    end

    applyStimulus(1'b0, 1'b0, mkInst(32'h20, 5'd3, 2'd0, 32'h77, 32'd0, 3'd0, 2'd0));
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    modelRetired = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b0, bubble);
    checkOutput("wrap.ret", bus.Retired_Out, 32'd0);
    checkModel("wrap");

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
